// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray converters and decoders.
// Functions work at MAX_W; callers zero-extend narrower words and truncate the result.
package gray_pkg;

  localparam int DEFAULT_W = 4;
  localparam int MAX_W     = 16;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A zero-extended Gray word decodes to the same zero-extended binary word.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_to_bin_stream_pipe_stage.sv
// Single valid/ready register slice; accepts whenever empty or draining.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/gray_to_bin_stream.sv
// Two-stage streaming Gray-to-binary decoder with step-error detection
// and a saturating step-error counter.
module gray_to_bin_stream
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_in_ready;
  logic             s1_valid;
  logic             s1_err;
  logic             s2_in_ready;
  logic [WIDTH-1:0] s1_gray;
  logic [WIDTH-1:0] s2_bin_next;
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic             step_err;
  logic             in_fire;
  logic             out_fire;

  // Hold the input closed for the whole time reset is asserted.
  assign in_ready = s1_in_ready && !rst;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign step_err    = have_prev && (popcount(MAX_W'(in_gray ^ prev_gray)) != 5'd1);
  assign s2_bin_next = WIDTH'(gray2bin(MAX_W'(s1_gray)));

  pipe_stage #(.W(WIDTH + 1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   ({in_gray, step_err}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  ({s1_gray, s1_err})
  );

  pipe_stage #(.W(WIDTH + 1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({s2_bin_next, s1_err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_bin, out_step_err})
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
    end else if (in_fire) begin
      prev_gray <= in_gray;
      have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_fire && out_step_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_to_bin_stream.sv
// Scoreboard bench for gray_to_bin_stream: table-driven streams plus
// hand-written stall, saturation and mid-stream reset sequences.
module tb_gray_to_bin_stream;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_gray = '0;

  logic         in_ready, out_valid, out_step_err;
  logic [W-1:0] out_bin;
  logic [7:0]   err_count;
  logic         sat_in_ready, sat_out_valid, sat_step_err;
  logic [W-1:0] sat_out_bin;
  logic [1:0]   sat_err_count;

  gray_to_bin_stream #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_step_err(out_step_err), .err_count(err_count)
  );

  gray_to_bin_stream #(.WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_gray(in_gray),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_bin(sat_out_bin),
    .out_step_err(sat_step_err), .err_count(sat_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         e;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [W:0] exp_q[$];
  vec_t       sweep[16];
  vec_t       spot[4];
  vec_t       rep[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Output side of the scoreboard: a word leaves on the next rising edge.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got bin=%h with empty scoreboard", out_bin);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] out bin=%h err=%b cnt=%0d", out_bin, out_step_err, err_count);
        chk("out_bin", 32'(out_bin), 32'(e[W:1]));
        chk("out_step_err", 32'(out_step_err), 32'(e[0]));
        chk("sat_out_word", 32'({sat_out_valid, sat_out_bin, sat_step_err}), 32'({1'b1, e}));
      end
    end
  end

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] b, input logic e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_gray  = g;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({b, e});
        $display("[TB] in  gray=%h", g);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: gray=%h not accepted, required acceptance within 50 cycles", g);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_in_ready", 32'({in_ready, sat_in_ready}), 32'd0);
    chk("rst_out_valid", 32'({out_valid, sat_out_valid}), 32'd0);
    chk("rst_out_word", 32'({out_bin, out_step_err}), 32'd0);
    chk("rst_err_count", 32'({err_count, sat_err_count}), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] sweep_g[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [1:0]   sat_exp[5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    for (int i = 0; i < 16; i++) sweep[i] = '{sweep_g[i], W'(i), 1'b0};
    spot[0] = '{4'b0000, 4'b0000, 1'b0};
    spot[1] = '{4'b0110, 4'b0100, 1'b1};
    spot[2] = '{4'b0011, 4'b0010, 1'b1};
    spot[3] = '{4'b1000, 4'b1111, 1'b0};
    rep[0]  = '{4'b0000, 4'b0000, 1'b0};
    rep[1]  = '{4'b0011, 4'b0010, 1'b1};
    rep[2]  = '{4'b0011, 4'b0010, 1'b1};
    rep[3]  = '{4'b0010, 4'b0011, 1'b0};

    #2;
    do_reset();

    // Monotonic sweep, back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(sweep[i].g, sweep[i].b, sweep[i].e);
    wait_drain();
    chk("sweep_err_count", 32'(err_count), 32'd0);

    // Spot decode with two jumps, including the two-edge latency.
    do_reset();
    send(spot[0].g, spot[0].b, spot[0].e);
    chk("latency_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < 3; i++) send(spot[i].g, spot[i].b, spot[i].e);
    wait_drain();
    chk("spot_err_count", 32'(err_count), 32'd2);
    do_reset();
    send(spot[3].g, spot[3].b, spot[3].e);
    wait_drain();

    // Step error and repeated word.
    do_reset();
    for (int i = 0; i < 4; i++) send(rep[i].g, rep[i].b, rep[i].e);
    wait_drain();
    chk("repeat_err_count", 32'(err_count), 32'd2);

    // Backpressure: two words fill the pipe, then the input closes.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 4'b0000;
    @(negedge clk);
    chk("bp_accept0", 32'(in_ready), 32'd1);
    exp_q.push_back({4'b0000, 1'b0});
    @(posedge clk);
    #1;
    in_gray = 4'b0001;
    @(negedge clk);
    chk("bp_accept1", 32'(in_ready), 32'd1);
    exp_q.push_back({4'b0001, 1'b0});
    @(posedge clk);
    #1;
    in_gray = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_hold", 32'({out_valid, out_bin}), 32'({1'b1, 4'b0000}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b0011, 4'b0010, 1'b0);
    send(4'b0010, 4'b0011, 1'b0);
    wait_drain();
    chk("bp_err_count", 32'(err_count), 32'd0);

    // Saturation on the narrow counter.
    do_reset();
    send(4'b0000, 4'b0000, 1'b0);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      send(4'b0000, 4'b0000, 1'b1);
      wait_drain();
      chk("sat_err_count", 32'(sat_err_count), 32'(sat_exp[k]));
      chk("wide_err_count", 32'(err_count), 32'(k + 1));
    end

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    send(4'b0001, 4'b0001, 1'b0);
    send(4'b0011, 4'b0010, 1'b0);
    #2;
    do_reset();
    out_ready = 1'b1;
    send(4'b0101, 4'b0110, 1'b0);
    send(4'b0111, 4'b0101, 1'b0);
    wait_drain();
    chk("post_reset_err_count", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
